// File: rtl/frame_uart_streamer.sv
// -----------------------------------------------------------------------------
// frame_uart_streamer
//
// Captures one edge-detector frame into on-chip RAM, then streams it out over
// an 8N1 UART as a framed packet: SYNC_WORD (MSB byte first), the payload
// bytes, and (when FRAME_CSUM_EN is defined) an XOR checksum of the payload.
//
// Optional feature macro: FRAME_CSUM_EN
//   defined   -> CSUM state appended after PAYLOAD, packet = NBYTES+3 bytes
//   undefined -> no checksum state or accumulator, packet = NBYTES+2 bytes
//
// Ports
//   clk          in   1           system clock
//   reset        in   1           asynchronous assert, synchronous release, active low
//   frame_start  in   1           1-cycle pulse: next pix_de beat is pixel 0
//   pix_de       in   1           pixel valid
//   pix_data     in   DATA_WIDTH  pixel value
//   tx           out  1           UART line, idle high
//   tx_busy      out  1           high from capture-complete through the DONE cycle
//   frame_sent   out  1           1-cycle pulse after the final stop bit
//   frame_drop   out  1           1-cycle pulse, one cycle after a frame_start
//                                 that arrived while the transmitter was busy
//
// Input handshake: pix_de is a valid-only qualifier (there is no ready). A beat
// is consumed on any clock where pix_de=1, the FSM is in CAPTURE and capture is
// armed (or frame_start arms it in the same cycle). Beats presented at any
// other time are dropped silently; frame_start while busy is reported on
// frame_drop instead of being queued.
// -----------------------------------------------------------------------------
module frame_uart_streamer #(
   parameter int          DATA_WIDTH = 8,
   parameter int          IMG_WIDTH  = 176,
   parameter int          IMG_HEIGHT = 240,
   parameter int          PACK_BITS  = 1,
   parameter int          CLK_HZ     = 100_000_000,
   parameter int          BAUD       = 115200,
   parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic                  pix_de,
   input  logic [DATA_WIDTH-1:0] pix_data,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  frame_sent,
   output logic                  frame_drop
);

   localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
   localparam int NBYTES = NPIX * PACK_BITS / 8;
   localparam int DIV    = CLK_HZ / BAUD;
   localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int ADDR_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int CNT_W  = $clog2(NBYTES + 1);
   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

   if (PACK_BITS != 1 && PACK_BITS != 8) begin : g_bad_pack
      $error("frame_uart_streamer: PACK_BITS must be 1 or 8");
   end
   if (((NPIX * PACK_BITS) % 8) != 0 || NBYTES < 1) begin : g_bad_size
      $error("frame_uart_streamer: frame does not pack into whole bytes");
   end
   if (DIV < 1) begin : g_bad_div
      $error("frame_uart_streamer: CLK_HZ/BAUD must be at least 1");
   end

   typedef enum logic [2:0] {
      CAPTURE = 3'd0,
      HDR_HI  = 3'd1,
      HDR_LO  = 3'd2,
      PAYLOAD = 3'd3,
`ifdef FRAME_CSUM_EN
      CSUM    = 3'd4,
`endif
      DONE    = 3'd5
   } state_t;

   state_t state, state_nxt;

   // ---------------------------------------------------------------- capture
   logic             armed;
   logic [PIX_W-1:0] pix_idx;
   logic [PIX_W-1:0] cap_idx;
   logic             cap_beat;
   logic             cap_done;

   // frame_start restarts the index in its own cycle, so a coincident beat
   // lands on pixel 0 and any partial frame is abandoned.
   always_comb begin
      cap_idx  = frame_start ? '0 : pix_idx;
      cap_beat = (state == CAPTURE) && pix_de && (frame_start || armed);
      cap_done = cap_beat && (cap_idx == PIX_W'(NPIX - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         armed   <= 1'b0;
         pix_idx <= '0;
      end else if (state == CAPTURE) begin
         if (cap_done) begin
            armed   <= 1'b0;
            pix_idx <= '0;
         end else if (cap_beat) begin
            armed   <= 1'b1;
            pix_idx <= cap_idx + 1'b1;
         end else if (frame_start) begin
            armed   <= 1'b1;
            pix_idx <= '0;
         end
      end
   end

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   if (PACK_BITS == 1) begin : g_pack1
      // Pixel 0 of each group of 8 ends up in bit 7 after eight shifts.
      logic [7:0] pack_sr;
      logic [7:0] pack_byte;

      assign pack_byte = {pack_sr[6:0], |pix_data};
      assign wr_en     = cap_beat && (cap_idx[2:0] == 3'b111);
      assign wr_addr   = ADDR_W'(cap_idx >> 3);
      assign wr_data   = pack_byte;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            pack_sr <= '0;
         end else if (cap_beat) begin
            pack_sr <= pack_byte;
         end
      end
   end else begin : g_pack8
      assign wr_en   = cap_beat;
      assign wr_addr = ADDR_W'(cap_idx);
      assign wr_data = 8'(pix_data);
   end

   // -------------------------------------------------------------------- RAM
   logic [7:0]        mem [0:NBYTES-1];
   logic [7:0]        rd_data;
   logic [CNT_W-1:0]  pay_cnt;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;

   // pay_cnt is the index of the next payload byte to load, so rd_data is
   // already holding it when the current byte's stop bit ends.
   assign rd_en   = (pay_cnt < CNT_W'(NBYTES));
   assign rd_addr = ADDR_W'(pay_cnt);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

   // ------------------------------------------------------------- serializer
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       bit_cnt;
   logic [8:0]       tx_sr;
   logic             tx_q;
   logic             byte_state;
   logic             bit_end;
   logic             byte_end;
   logic             load;
   logic [7:0]       next_byte;

`ifdef FRAME_CSUM_EN
   logic [7:0] csum;
`endif

   assign byte_state = (state != CAPTURE) && (state != DONE);
   assign bit_end    = byte_state && (div_cnt == DIV_W'(DIV - 1));
   assign byte_end   = bit_end && (bit_cnt == 4'd9);

   always_comb begin
      state_nxt = state;
      case (state)
         CAPTURE: if (cap_done) state_nxt = HDR_HI;
         HDR_HI:  if (byte_end) state_nxt = HDR_LO;
         HDR_LO:  if (byte_end) state_nxt = PAYLOAD;
         PAYLOAD: begin
            if (byte_end && (pay_cnt == CNT_W'(NBYTES))) begin
`ifdef FRAME_CSUM_EN
               state_nxt = CSUM;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef FRAME_CSUM_EN
         CSUM:    if (byte_end) state_nxt = DONE;
`endif
         DONE:    state_nxt = CAPTURE;
         default: state_nxt = CAPTURE;
      endcase
   end

   // A new byte starts either when capture completes or when a stop bit ends
   // and the packet is not yet finished; this keeps bytes back to back.
   always_comb begin
      load      = ((state == CAPTURE) && cap_done) ||
                  (byte_end && (state_nxt != DONE));
      next_byte = 8'hFF;
      case (state_nxt)
         HDR_HI:  next_byte = SYNC_WORD[15:8];
         HDR_LO:  next_byte = SYNC_WORD[7:0];
         PAYLOAD: next_byte = rd_data;
`ifdef FRAME_CSUM_EN
         CSUM:    next_byte = csum;
`endif
         default: next_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= CAPTURE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         tx_sr      <= '1;
         tx_q       <= 1'b1;
         pay_cnt    <= '0;
         frame_drop <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_drop <= frame_start && (state != CAPTURE);
         if (load) begin
            // Start bit goes out now; data bits and stop bit follow from tx_sr.
            tx_q    <= 1'b0;
            tx_sr   <= {1'b1, next_byte};
            div_cnt <= '0;
            bit_cnt <= '0;
            if (state_nxt == HDR_HI) begin
               pay_cnt <= '0;
            end else if (state_nxt == PAYLOAD) begin
               pay_cnt <= pay_cnt + 1'b1;
            end
         end else if (byte_end) begin
            tx_q    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
         end else if (bit_end) begin
            tx_q    <= tx_sr[0];
            tx_sr   <= {1'b1, tx_sr[8:1]};
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
         end else if (byte_state) begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

`ifdef FRAME_CSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csum <= '0;
      end else if (load && (state_nxt == HDR_HI)) begin
         csum <= '0;
      end else if (load && (state_nxt == PAYLOAD)) begin
         csum <= csum ^ rd_data;
      end
   end
`endif

   assign tx         = tx_q;
   assign tx_busy    = (state != CAPTURE);
   assign frame_sent = (state == DONE);

endmodule

// File: tb/tb_frame_uart_streamer.sv
// -----------------------------------------------------------------------------
// tb_frame_uart_streamer
//
// Two instances: dut0 packs a 4x4 binary frame (PACK_BITS=1), dut1 sends a
// 2x2 raw-byte frame (PACK_BITS=8); both run at DIV=16 clocks per bit.
// The model turns each frame into its byte list and derives the expected UART
// waveform cycle by cycle; a negedge process compares every output.
// -----------------------------------------------------------------------------
module tb_frame_uart_streamer;

   localparam int DIV      = 16;
   localparam int BYTE_CYC = 10 * DIV;

   // ------------------------------------------------------ clock and reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       fs0, de0, fs1, de1;
   logic [7:0] pd0, pd1;
   logic       tx0, busy0, sent0, drop0;
   logic       tx1, busy1, sent1, drop1;

   frame_uart_streamer #(
      .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .PACK_BITS(1),
      .CLK_HZ(16), .BAUD(1), .SYNC_WORD(16'hA55A)
   ) dut0 (
      .clk(clk), .reset(reset), .frame_start(fs0), .pix_de(de0), .pix_data(pd0),
      .tx(tx0), .tx_busy(busy0), .frame_sent(sent0), .frame_drop(drop0)
   );

   frame_uart_streamer #(
      .DATA_WIDTH(8), .IMG_WIDTH(2), .IMG_HEIGHT(2), .PACK_BITS(8),
      .CLK_HZ(16), .BAUD(1), .SYNC_WORD(16'hA55A)
   ) dut1 (
      .clk(clk), .reset(reset), .frame_start(fs1), .pix_de(de1), .pix_data(pd1),
      .tx(tx1), .tx_busy(busy1), .frame_sent(sent1), .frame_drop(drop1)
   );

   // ------------------------------------------------------------ scoreboard
   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   logic [7:0] f0[16];
   logic [7:0] f1[4];
   int  checks = 0;
   int  errors = 0;
   bit  act[2], arm[2], drop_arm[2], drop_exp[2];
   int  kk[2];
   int  dut_sent[2];
   int  pk_issued[2];

   task automatic chk(input string name, input int d, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, d, $time, got, exp);
      end
   endtask

   // ----------------------------------------------------------------- model
   task automatic build(input int d);
      logic [15:0] sync_w;
      logic [7:0]  b;
      logic [7:0]  cs;
      logic [7:0]  pkt[$];
      sync_w = 16'hA55A;
      cs     = 8'h00;
      pkt.push_back(sync_w[15:8]);
      pkt.push_back(sync_w[7:0]);
      if (d == 0) begin
         for (int j = 0; j < 2; j++) begin
            b = 8'h00;
            for (int p = 0; p < 8; p++) begin
               if (f0[8 * j + p] != 8'h00) b[7 - p] = 1'b1;
            end
            pkt.push_back(b);
            cs = cs ^ b;
         end
      end else begin
         for (int j = 0; j < 4; j++) begin
            pkt.push_back(f1[j]);
            cs = cs ^ f1[j];
         end
      end
`ifdef FRAME_CSUM_EN
      pkt.push_back(cs);
`endif
      if (d == 0) exp_q0 = pkt;
      else        exp_q1 = pkt;
   endtask

   task automatic pin_model(input int d, input logic [7:0] lit[$]);
`ifdef FRAME_CSUM_EN
      logic [7:0] cs;
      cs = 8'h00;
      for (int i = 2; i < lit.size(); i++) cs = cs ^ lit[i];
      lit.push_back(cs);
`endif
      chk("model_len", d, (d == 0) ? exp_q0.size() : exp_q1.size(), lit.size());
      for (int i = 0; i < lit.size(); i++) begin
         chk("model_byte", d, (d == 0) ? exp_q0[i] : exp_q1[i], lit[i]);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int d, input int i);
      return (d == 0) ? exp_q0[i] : exp_q1[i];
   endfunction

   function automatic int exp_len(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   // --------------------------------------------------------------- compare
   task automatic cmp_dut(input int d, input logic t, input logic b,
                          input logic s, input logic dr);
      logic       etx, eb, es, ed;
      logic [7:0] by;
      int         total, bt;
      etx = 1'b1; eb = 1'b0; es = 1'b0; ed = 1'b0;
      if (reset === 1'b1) begin
         if (act[d]) begin
            total = exp_len(d) * BYTE_CYC;
            eb    = 1'b1;
            if (kk[d] < total) begin
               by  = exp_byte(d, kk[d] / BYTE_CYC);
               bt  = (kk[d] % BYTE_CYC) / DIV;
               etx = (bt == 0) ? 1'b0 : (bt == 9) ? 1'b1 : by[bt - 1];
            end else begin
               es     = 1'b1;
               act[d] = 1'b0;
            end
            kk[d]++;
         end
         if (arm[d]) begin
            arm[d] = 1'b0;
            act[d] = 1'b1;
            kk[d]  = 0;
         end
         ed          = drop_exp[d];
         drop_exp[d] = drop_arm[d];
         drop_arm[d] = 1'b0;
      end
      if (s === 1'b1) dut_sent[d]++;
      chk("tx", d, t, etx);
      chk("tx_busy", d, b, eb);
      chk("frame_sent", d, s, es);
      chk("frame_drop", d, dr, ed);
   endtask

   always @(negedge clk) begin
      cmp_dut(0, tx0, busy0, sent0, drop0);
      cmp_dut(1, tx1, busy1, sent1, drop1);
   end

   // --------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int d, input logic fs, input logic de, input logic [7:0] pd);
      if (d == 0) begin fs0 = fs; de0 = de; pd0 = pd; end
      else        begin fs1 = fs; de1 = de; pd1 = pd; end
   endtask

   task automatic send_frame(input int d, input bit coincide);
      int n;
      n = (d == 0) ? 16 : 4;
      if (!coincide) begin
         tick();
         set_in(d, 1'b1, 1'b0, 8'h00);
      end
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            tick();
            set_in(d, 1'b0, 1'b0, 8'h00);
         end
         tick();
         set_in(d, coincide && (i == 0), 1'b1, (d == 0) ? f0[i] : f1[i]);
         if (i == n - 1) begin
            arm[d] = 1'b1;
            pk_issued[d]++;
         end
      end
      tick();
      set_in(d, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic stray_beats(input int d, input int n, input logic [7:0] v);
      for (int i = 0; i < n; i++) begin
         tick();
         set_in(d, 1'b0, 1'b1, v);
      end
      tick();
      set_in(d, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic pulse_fs(input int d);
      tick();
      set_in(d, 1'b1, 1'b0, 8'h00);
      if (act[d] || arm[d]) drop_arm[d] = 1'b1;
      tick();
      set_in(d, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      while ((act[d] || arm[d]) && n < 3000) begin
         tick();
         n++;
      end
      checks++;
      if (act[d] || arm[d]) begin
         errors++;
         $display("FAIL wait_idle dut%0d t=%0t got=busy_after_%0d_cycles expected=idle", d, $time, n);
      end
      repeat (20) tick();
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      logic [7:0] lit[$];
      reset = 1'b1;
      set_in(0, 1'b0, 1'b0, 8'h00);
      set_in(1, 1'b0, 1'b0, 8'h00);
      #2 reset = 1'b0;
      repeat (3) tick();
      chk("reset_tx", 0, tx0, 1'b1);
      chk("reset_busy", 0, busy0, 1'b0);
      chk("reset_tx", 1, tx1, 1'b1);
      chk("reset_busy", 1, busy1, 1'b0);
      reset = 1'b1;

      // beats before any frame_start are ignored
      stray_beats(0, 20, 8'hFF);
      stray_beats(1, 6, 8'h55);
      repeat (40) tick();

      // alternating 0xFF/0x00 frame
      for (int i = 0; i < 16; i++) f0[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
      build(0);
      lit = '{8'hA5, 8'h5A, 8'hAA, 8'hAA};
      pin_model(0, lit);
      send_frame(0, 1'b0);
      wait_idle(0);

      // frame_start and pixels while busy: dropped, packet unchanged
      send_frame(0, 1'b0);
      repeat (50) tick();
      pulse_fs(0);
      stray_beats(0, 16, 8'h00);
      repeat (200) tick();
      pulse_fs(0);
      wait_idle(0);

      // single set pixel at index 15
      for (int i = 0; i < 16; i++) f0[i] = 8'h00;
      f0[15] = 8'h01;
      build(0);
      lit = '{8'hA5, 8'h5A, 8'h00, 8'h01};
      pin_model(0, lit);
      send_frame(0, 1'b0);
      wait_idle(0);

      // partial frame of 5 pixels, then restart coincident with pixel 0
      tick();
      set_in(0, 1'b1, 1'b0, 8'h00);
      stray_beats(0, 5, 8'h00);
      for (int i = 0; i < 16; i++) f0[i] = 8'hFF;
      build(0);
      lit = '{8'hA5, 8'h5A, 8'hFF, 8'hFF};
      pin_model(0, lit);
      send_frame(0, 1'b1);
      wait_idle(0);

      // raw byte packing
      f1 = '{8'h11, 8'h22, 8'h33, 8'h44};
      build(1);
      lit = '{8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
      pin_model(1, lit);
      send_frame(1, 1'b0);
      wait_idle(1);

      // reset during the HDR_LO start bit
      for (int i = 0; i < 16; i++) f0[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
      build(0);
      send_frame(0, 1'b0);
      pk_issued[0]--;
      repeat (165) @(posedge clk);
      #2;
      chk("hdr_lo_start_bit", 0, tx0, 1'b0);
      #1;
      reset = 1'b0;
      act[0] = 1'b0; arm[0] = 1'b0; drop_arm[0] = 1'b0; drop_exp[0] = 1'b0;
      #1;
      chk("reset_mid_tx", 0, tx0, 1'b1);
      chk("reset_mid_busy", 0, busy0, 1'b0);
      repeat (3) tick();
      reset = 1'b1;
      stray_beats(0, 16, 8'hFF);
      repeat (200) tick();

      // fresh random frames on both instances after the reset
      for (int i = 0; i < 16; i++) f0[i] = ($urandom_range(0, 1) == 1) ? 8'(8'($urandom_range(1, 255))) : 8'h00;
      for (int i = 0; i < 4; i++) f1[i] = 8'($urandom_range(0, 255));
      build(0);
      build(1);
      send_frame(0, 1'b0);
      wait_idle(0);
      send_frame(1, 1'b1);
      wait_idle(1);

      chk("frame_sent_count", 0, dut_sent[0], pk_issued[0]);
      chk("frame_sent_count", 1, dut_sent[1], pk_issued[1]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t got=running expected=finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
